// File: rtl/uart_tx_engine.sv
// UART transmit path: a 16-entry byte FIFO feeding an LCR-configured serializer.
// One serial bit spans 16 enable ticks; frame format is latched when a byte is popped.
module uart_tx_engine #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_PTR_W = 4,
    parameter int FIFO_CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  wb_rst_i,
    input  logic [7:0]            lcr,
    input  logic                  tf_push,
    input  logic [7:0]            wb_dat_i,
    input  logic                  enable,
    input  logic                  tx_reset,
    output logic                  stx_pad_o,
    output logic [2:0]            state,
    output logic [FIFO_CNT_W-1:0] tf_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    tx_state_t             st;
    logic [7:0]            fifo_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic [7:0]            head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push_ok;
    logic                  pop;

    logic [3:0]            tick;
    logic [2:0]            bit_idx;
    logic                  stop_ext;
    logic                  line_bit;
    logic                  tick_last;
    logic                  stop_last;
    logic                  brk;

    logic [7:0]            shreg;
    logic [1:0]            wlen;
    logic                  par_en;
    logic                  stop2;
    logic                  par_bit;
    logic                  lcr_unused;

    function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] wl,
                                         input logic even, input logic stick);
        logic [7:0] mask;
        logic       p;
        mask = 8'hFF >> (2'd3 - wl);
        p    = ^(d & mask);
        if (stick)
            return ~even;
        return even ? p : ~p;
    endfunction

    assign lcr_unused = lcr[7];
    assign brk        = lcr[6];
    assign state      = st;
    assign head       = fifo_mem[rd_ptr];
    assign fifo_full  = (tf_count == FIFO_CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (tf_count == '0);
    assign push_ok    = tf_push && !tx_reset && !fifo_full;
    assign tick_last  = (tick == 4'd15);

    // Long stop: a full 16-tick pass, then an extension of 8 (5-bit words) or 16 ticks.
    assign stop_last  = stop_ext ? (tick == ((wlen == 2'd0) ? 4'd7 : 4'd15))
                                 : (tick_last && !stop2);

    assign pop = enable && !tx_reset && !fifo_empty &&
                 ((st == S_IDLE) || ((st == S_STOP) && stop_last));

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= wb_dat_i;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tf_count <= '0;
        end else if (tx_reset) begin
            rd_ptr   <= wr_ptr;
            tf_count <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                tf_count <= tf_count + 1'b1;
            else if (pop && !push_ok)
                tf_count <= tf_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shreg   <= head;
            wlen    <= lcr[1:0];
            stop2   <= lcr[2];
            par_en  <= lcr[3];
            par_bit <= calc_parity(head, lcr[1:0], lcr[4], lcr[5]);
        end else if (enable && (st == S_DATA) && tick_last) begin
            shreg <= {1'b0, shreg[7:1]};
        end
    end

    // Break overrides the wire every cycle; transitions also drive the new bit straight out.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            st        <= S_IDLE;
            tick      <= '0;
            bit_idx   <= '0;
            stop_ext  <= 1'b0;
            line_bit  <= 1'b1;
            stx_pad_o <= 1'b1;
        end else begin
            stx_pad_o <= ~brk & line_bit;
            if (enable) begin
                case (st)
                    S_IDLE: begin
                        if (pop) begin
                            st        <= S_START;
                            tick      <= '0;
                            line_bit  <= 1'b0;
                            stx_pad_o <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (tick_last) begin
                            st        <= S_DATA;
                            tick      <= '0;
                            bit_idx   <= '0;
                            line_bit  <= shreg[0];
                            stx_pad_o <= ~brk & shreg[0];
                        end else begin
                            tick <= tick + 4'd1;
                        end
                    end
                    S_DATA: begin
                        if (tick_last) begin
                            tick <= '0;
                            if (bit_idx == ({1'b0, wlen} + 3'd4)) begin
                                if (par_en) begin
                                    st        <= S_PARITY;
                                    line_bit  <= par_bit;
                                    stx_pad_o <= ~brk & par_bit;
                                end else begin
                                    st        <= S_STOP;
                                    stop_ext  <= 1'b0;
                                    line_bit  <= 1'b1;
                                    stx_pad_o <= ~brk;
                                end
                            end else begin
                                bit_idx   <= bit_idx + 3'd1;
                                line_bit  <= shreg[1];
                                stx_pad_o <= ~brk & shreg[1];
                            end
                        end else begin
                            tick <= tick + 4'd1;
                        end
                    end
                    S_PARITY: begin
                        if (tick_last) begin
                            st        <= S_STOP;
                            tick      <= '0;
                            stop_ext  <= 1'b0;
                            line_bit  <= 1'b1;
                            stx_pad_o <= ~brk;
                        end else begin
                            tick <= tick + 4'd1;
                        end
                    end
                    S_STOP: begin
                        if (stop_last) begin
                            tick     <= '0;
                            stop_ext <= 1'b0;
                            if (pop) begin
                                st        <= S_START;
                                line_bit  <= 1'b0;
                                stx_pad_o <= 1'b0;
                            end else begin
                                st        <= S_IDLE;
                                line_bit  <= 1'b1;
                                stx_pad_o <= ~brk;
                            end
                        end else if (tick_last) begin
                            tick     <= '0;
                            stop_ext <= 1'b1;
                        end else begin
                            tick <= tick + 4'd1;
                        end
                    end
                    default: begin
                        st        <= S_IDLE;
                        tick      <= '0;
                        line_bit  <= 1'b1;
                        stx_pad_o <= ~brk;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frames are decoded from stx_pad_o at mid-bit
// with enable pulsing every 4 clocks, so one bit lasts 64 clocks.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic [7:0] lcr;
    logic       tf_push;
    logic [7:0] wb_dat_i;
    logic       enable;
    logic       tx_reset;
    logic       stx_pad_o;
    logic [2:0] state;
    logic [4:0] tf_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit en_run = 1'b0;
    int en_cnt = 0;

    uart_tx_engine #(.FIFO_DEPTH(16), .FIFO_PTR_W(4), .FIFO_CNT_W(5)) dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .lcr       (lcr),
        .tf_push   (tf_push),
        .wb_dat_i  (wb_dat_i),
        .enable    (enable),
        .tx_reset  (tx_reset),
        .stx_pad_o (stx_pad_o),
        .state     (state),
        .tf_count  (tf_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en_run) begin
            en_cnt = en_cnt + 1;
            enable = (en_cnt % 4 == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        tf_push  = 1'b1;
        wb_dat_i = b;
        @(negedge clk);
        tf_push  = 1'b0;
    endtask

    task automatic start_en();
        @(negedge clk);
        en_cnt = 0;
        en_run = 1'b1;
    endtask

    task automatic stop_en();
        @(negedge clk);
        en_run = 1'b0;
        enable = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (!(state === 3'd0 && tf_count === 5'd0) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (n < 20000);
    endtask

    task automatic wait_state(input logic [2:0] s, output bit ok);
        int n = 0;
        while (state !== s && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (n < 5000);
    endtask

    task automatic capture_frame(input int nbits, input bit has_par,
                                 output logic [7:0] data, output logic par,
                                 output logic start_ok, output int stop_len,
                                 output int start_cyc, output bit timeout);
        int n = 0;
        data = 8'h00; par = 1'bx; start_ok = 1'b0; stop_len = 0; start_cyc = 0;
        timeout = 1'b0;
        while (stx_pad_o !== 1'b0 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20000) begin
            timeout = 1'b1;
            return;
        end
        start_cyc = cyc;
        repeat (32) @(posedge clk);
        #1;
        start_ok = (stx_pad_o === 1'b0);
        for (int i = 0; i < nbits; i++) begin
            repeat (64) @(posedge clk);
            #1;
            data[i] = stx_pad_o;
        end
        if (has_par) begin
            repeat (64) @(posedge clk);
            #1;
            par = stx_pad_o;
        end
        n = 0;
        while (state !== 3'd4 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) begin
            timeout = 1'b1;
            return;
        end
        while (state === 3'd4 && stop_len < 400) begin
            @(posedge clk); #1;
            stop_len++;
        end
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1; tf_push = 1'b0; enable = 1'b0; tx_reset = 1'b0;
        lcr = 8'h03; wb_dat_i = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++; if (stx_pad_o !== 1'b1) begin bad++; $display("FAIL reset_stx got=%b exp=1", stx_pad_o); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (tf_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", tf_count); end
        @(negedge clk);
        wb_rst_i = 1'b0;
    endtask

    task automatic test_8n1();
        logic [7:0] d; logic p, sok; int sl, sc; bit to, ok;
        lcr = 8'h03;
        push_byte(8'hA5);
        @(posedge clk); #1;
        total++; if (tf_count !== 5'd1) begin bad++; $display("FAIL 8n1_count_push got=%0d exp=1", tf_count); end
        start_en();
        capture_frame(8, 1'b0, d, p, sok, sl, sc, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL 8n1_timeout got=%b exp=0", to); end
        total++; if (sok !== 1'b1) begin bad++; $display("FAIL 8n1_start got=%b exp=1", sok); end
        total++; if (d !== 8'hA5) begin bad++; $display("FAIL 8n1_data got=%h exp=a5", d); end
        total++; if (sl !== 64) begin bad++; $display("FAIL 8n1_stop_len got=%0d exp=64", sl); end
        total++; if (tf_count !== 5'd0) begin bad++; $display("FAIL 8n1_count_pop got=%0d exp=0", tf_count); end
        wait_idle(ok);
        total++; if (ok !== 1'b1 || stx_pad_o !== 1'b1) begin bad++; $display("FAIL 8n1_idle got ok=%b stx=%b exp ok=1 stx=1", ok, stx_pad_o); end
        stop_en();
    endtask

    task automatic test_parity();
        logic [7:0] cfg [3] = '{8'h1E, 8'h0E, 8'h2E};
        logic       exp [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] d; logic p, sok; int sl, sc; bit to, ok;
        for (int k = 0; k < 3; k++) begin
            lcr = cfg[k];
            push_byte(8'h53);
            start_en();
            capture_frame(7, 1'b1, d, p, sok, sl, sc, to);
            total++; if (to !== 1'b0 || sok !== 1'b1) begin bad++; $display("FAIL par_start lcr=%h got to=%b start=%b exp 0/1", cfg[k], to, sok); end
            total++; if (d !== 8'h53) begin bad++; $display("FAIL par_data lcr=%h got=%h exp=53", cfg[k], d); end
            total++; if (p !== exp[k]) begin bad++; $display("FAIL par_bit lcr=%h got=%b exp=%b", cfg[k], p, exp[k]); end
            total++; if (sl !== 128) begin bad++; $display("FAIL par_stop_len lcr=%h got=%0d exp=128", cfg[k], sl); end
            wait_idle(ok);
            stop_en();
        end
    endtask

    task automatic test_5bit_2stop();
        logic [7:0] d; logic p, sok; int sl, sc; bit to, ok;
        lcr = 8'h04;
        push_byte(8'h1F);
        start_en();
        capture_frame(5, 1'b0, d, p, sok, sl, sc, to);
        total++; if (to !== 1'b0 || sok !== 1'b1) begin bad++; $display("FAIL w5_start got to=%b start=%b exp 0/1", to, sok); end
        total++; if (d !== 8'h1F) begin bad++; $display("FAIL w5_data got=%h exp=1f", d); end
        total++; if (sl !== 96) begin bad++; $display("FAIL w5_stop_len got=%0d exp=96", sl); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL w5_idle got=%0d exp=0", state); end
        wait_idle(ok);
        stop_en();
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] d; logic p, sok; int sl, sc, prev; bit to;
        lcr = 8'h00;
        prev = 0;
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        @(posedge clk); #1;
        total++; if (tf_count !== 5'd16) begin bad++; $display("FAIL fifo_full_count got=%0d exp=16", tf_count); end
        start_en();
        for (int f = 0; f < 16; f++) begin
            capture_frame(5, 1'b0, d, p, sok, sl, sc, to);
            total++; if (to !== 1'b0 || d !== 8'(f)) begin bad++; $display("FAIL fifo_frame%0d got=%h to=%b exp=%h", f, d, to, 8'(f)); end
            if (f > 0) begin
                total++; if (sc - prev !== 448) begin bad++; $display("FAIL fifo_gap%0d got=%0d exp=448", f, sc - prev); end
            end
            prev = sc;
        end
        repeat (300) @(posedge clk);
        #1;
        total++; if (state !== 3'd0 || stx_pad_o !== 1'b1 || tf_count !== 5'd0) begin
            bad++; $display("FAIL fifo_no_17th got state=%0d stx=%b cnt=%0d exp 0/1/0", state, stx_pad_o, tf_count);
        end
        stop_en();
    endtask

    task automatic test_flush_mid_char();
        logic [7:0] d; logic p, sok; int sl, sc; bit to, ok;
        lcr = 8'h03;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        start_en();
        fork
            capture_frame(8, 1'b0, d, p, sok, sl, sc, to);
            begin
                wait_state(3'd2, ok);
                repeat (40) @(posedge clk);
                #1;
                total++; if (tf_count !== 5'd2) begin bad++; $display("FAIL flush_pre_count got=%0d exp=2", tf_count); end
                @(negedge clk);
                tx_reset = 1'b1; tf_push = 1'b1; wb_dat_i = 8'h44;
                @(posedge clk); #1;
                total++; if (tf_count !== 5'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", tf_count); end
                @(negedge clk);
                tx_reset = 1'b0; tf_push = 1'b0;
            end
        join
        total++; if (to !== 1'b0 || d !== 8'h11) begin bad++; $display("FAIL flush_byte1 got=%h to=%b exp=11", d, to); end
        total++; if (sl !== 64) begin bad++; $display("FAIL flush_stop_len got=%0d exp=64", sl); end
        repeat (300) @(posedge clk);
        #1;
        total++; if (state !== 3'd0 || stx_pad_o !== 1'b1 || tf_count !== 5'd0) begin
            bad++; $display("FAIL flush_idle got state=%0d stx=%b cnt=%0d exp 0/1/0", state, stx_pad_o, tf_count);
        end
        stop_en();
    endtask

    task automatic test_break_and_simul();
        bit ok;
        lcr = 8'h03;
        push_byte(8'hFF);
        start_en();
        wait_state(3'd2, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL brk_reach_data got=%b exp=1", ok); end
        repeat (10) @(posedge clk);
        @(negedge clk);
        lcr = 8'h43;
        @(posedge clk); #1;
        total++; if (stx_pad_o !== 1'b0) begin bad++; $display("FAIL brk_on got=%b exp=0", stx_pad_o); end
        repeat (20) @(posedge clk);
        #1;
        total++; if (stx_pad_o !== 1'b0 || state !== 3'd2) begin bad++; $display("FAIL brk_hold got stx=%b state=%0d exp 0/2", stx_pad_o, state); end
        @(negedge clk);
        lcr = 8'h03;
        @(posedge clk); #1;
        total++; if (stx_pad_o !== 1'b1) begin bad++; $display("FAIL brk_off got=%b exp=1", stx_pad_o); end
        wait_idle(ok);
        stop_en();

        push_byte(8'hAA);
        push_byte(8'hBB);
        @(negedge clk);
        enable = 1'b1; tf_push = 1'b1; wb_dat_i = 8'hCC;
        @(posedge clk); #1;
        total++; if (tf_count !== 5'd2) begin bad++; $display("FAIL simul_count got=%0d exp=2", tf_count); end
        total++; if (state !== 3'd1 || stx_pad_o !== 1'b0) begin bad++; $display("FAIL simul_pop got state=%0d stx=%b exp 1/0", state, stx_pad_o); end
        @(negedge clk);
        enable = 1'b0; tf_push = 1'b0;
        start_en();
        wait_idle(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL simul_drain got=%b exp=1", ok); end
        stop_en();
    endtask

    task automatic test_reset_mid();
        bit ok;
        lcr = 8'h03;
        push_byte(8'h5A);
        push_byte(8'h5B);
        start_en();
        wait_state(3'd2, ok);
        repeat (5) @(posedge clk);
        @(negedge clk);
        wb_rst_i = 1'b1;
        #1;
        total++; if (stx_pad_o !== 1'b1 || state !== 3'd0 || tf_count !== 5'd0) begin
            bad++; $display("FAIL rst_mid got stx=%b state=%0d cnt=%0d exp 1/0/0", stx_pad_o, state, tf_count);
        end
        stop_en();
        wb_rst_i = 1'b0;
        @(posedge clk); #1;
        total++; if (state !== 3'd0 || tf_count !== 5'd0) begin bad++; $display("FAIL rst_after got state=%0d cnt=%0d exp 0/0", state, tf_count); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_5bit_2stop();
        test_fifo_overflow();
        test_flush_mid_char();
        test_break_and_simul();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
